// File: rtl/goertzel_pkg.sv
// Shared types and width helpers for the Goertzel filter and its block-end power stage.
package goertzel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQ0,
    SQ1,
    CS,
    CROSS,
    OUT
  } goertzel_pwr_state_t;

  typedef enum logic [1:0] {
    MAC_HOLD,
    MAC_LOAD,
    MAC_ADD,
    MAC_SUB
  } mac_op_t;

  function automatic int state_w_from_dw(input int dw);
    return dw + 2;
  endfunction

  function automatic int pw_from_dw(input int dw);
    return 2 * state_w_from_dw(dw);
  endfunction

endpackage

// File: rtl/goertzel_power_if.sv
// Filter-state input / power-result handshake bundle for goertzel_power.
interface goertzel_power_if #(
  parameter int DW              = 14,
  parameter int BLOCK_SIZE_POW2 = 8
);
  localparam int W  = goertzel_pkg::state_w_from_dw(DW);
  localparam int PW = goertzel_pkg::pw_from_dw(DW);

  logic signed [W-1:0]         s0_i;
  logic signed [W-1:0]         s1_i;
  logic                        valid_i;
  logic [BLOCK_SIZE_POW2-1:0]  count_i;
  logic                        clr_o;
  logic [PW-1:0]               power_o;
  logic                        valid_o;
  logic                        ready_i;
  logic                        overrun_o;

  // The power block is the slave: it consumes filter state and drives results.
  modport slave (
    input  s0_i, s1_i, valid_i, count_i, ready_i,
    output clr_o, power_o, valid_o, overrun_o
  );

  modport master (
    output s0_i, s1_i, valid_i, count_i, ready_i,
    input  clr_o, power_o, valid_o, overrun_o
  );

endinterface

// File: rtl/goertzel_mac.sv
// Single signed multiplier feeding a registered accumulator with load/add/subtract/hold.
module goertzel_mac
  import goertzel_pkg::*;
#(
  parameter int MW = 18,
  parameter int AW = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  mac_op_t                op,
  input  logic signed [MW-1:0]   a,
  input  logic signed [MW-1:0]   b,
  output logic signed [2*MW-1:0] prod,
  output logic signed [AW-1:0]   acc_next
);

  logic signed [AW-1:0] acc_reg;
  logic signed [AW-1:0] prod_ext;

  assign prod     = a * b;
  // Every product routed into the accumulator fits in AW bits.
  assign prod_ext = prod[AW-1:0];

  always_comb begin
    acc_next = acc_reg;
    unique case (op)
      MAC_LOAD: acc_next = prod_ext;
      MAC_ADD:  acc_next = acc_reg + prod_ext;
      MAC_SUB:  acc_next = acc_reg - prod_ext;
      default:  acc_next = acc_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/goertzel_power.sv
// Block-end Goertzel power |X|^2 = s0^2 + s1^2 - COEFF*s0*s1 on one shared multiplier,
// with filter clear, overrun flag and a valid/ready result port.
module goertzel_power
  import goertzel_pkg::*;
#(
  parameter int COEFF           = 0,
  parameter int COEFF_BITS      = 18,
  parameter int DW              = 14,
  parameter int BLOCK_SIZE_POW2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  goertzel_power_if.slave  bus
);

  localparam int W    = state_w_from_dw(DW);
  localparam int PW   = pw_from_dw(DW);
  localparam int FRAC = COEFF_BITS - 2;
  // t keeps an extra bit so COEFF = -2.0 at the most negative s0 cannot wrap.
  localparam int TW   = W + 2;
  localparam int MW   = (TW > COEFF_BITS) ? TW : COEFF_BITS;
  localparam int AW   = 2 * W + 2;
  localparam logic signed [MW-1:0] COEFF_MW = MW'(COEFF);

  goertzel_pwr_state_t    state_reg, state_next;
  logic signed [W-1:0]    s0_reg, s1_reg;
  logic signed [TW-1:0]   t_reg;
  logic [PW-1:0]          power_reg, power_next;

  mac_op_t                mac_op;
  logic signed [MW-1:0]   mul_a, mul_b;
  logic signed [2*MW-1:0] prod;
  logic signed [AW-1:0]   acc_next;

  logic block_end;
  logic capture;

  assign block_end = bus.valid_i && (&bus.count_i);
  assign capture   = block_end && (state_reg == IDLE);

  goertzel_mac #(
    .MW (MW),
    .AW (AW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .op       (mac_op),
    .a        (mul_a),
    .b        (mul_b),
    .prod     (prod),
    .acc_next (acc_next)
  );

  always_comb begin
    state_next = state_reg;
    mac_op     = MAC_HOLD;
    mul_a      = '0;
    mul_b      = '0;
    unique case (state_reg)
      IDLE: begin
        if (block_end) state_next = SQ0;
      end
      SQ0: begin
        mac_op     = MAC_LOAD;
        mul_a      = MW'(s0_reg);
        mul_b      = MW'(s0_reg);
        state_next = SQ1;
      end
      SQ1: begin
        mac_op     = MAC_ADD;
        mul_a      = MW'(s1_reg);
        mul_b      = MW'(s1_reg);
        state_next = CS;
      end
      CS: begin
        mul_a      = MW'(s0_reg);
        mul_b      = COEFF_MW;
        state_next = CROSS;
      end
      CROSS: begin
        mac_op     = MAC_SUB;
        mul_a      = MW'(t_reg);
        mul_b      = MW'(s1_reg);
        state_next = OUT;
      end
      OUT: begin
        if (bus.ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clamp the signed accumulator into the unsigned power range.
  always_comb begin
    power_next = acc_next[PW-1:0];
    if (acc_next[AW-1]) begin
      power_next = '0;
    end else if (|acc_next[AW-2:PW]) begin
      power_next = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      s0_reg    <= '0;
      s1_reg    <= '0;
      t_reg     <= '0;
      power_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        s0_reg <= bus.s0_i;
        s1_reg <= bus.s1_i;
      end
      if (state_reg == CS) begin
        t_reg <= TW'(prod >>> FRAC);
      end
      if (state_reg == CROSS) begin
        power_reg <= power_next;
      end
    end
  end

  assign bus.clr_o     = (state_reg == SQ0);
  assign bus.valid_o   = (state_reg == OUT);
  assign bus.power_o   = power_reg;
  assign bus.overrun_o = block_end && (state_reg != IDLE);

endmodule

// File: tb/tb_goertzel_power.sv
// Self-checking bench: four goertzel_power instances with different COEFF share one stimulus stream.
module tb_goertzel_power;

  localparam int DW   = 14;
  localparam int CB   = 18;
  localparam int BS   = 3;
  localparam int W    = DW + 2;
  localparam int PW   = 2 * W;
  localparam int FRAC = CB - 2;
  localparam int NDUT = 4;
  localparam int COEFF_TAB [NDUT] = '{0, 65536, -131072, 92682};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W-1:0] s0;
  logic signed [W-1:0] s1;
  logic                valid_in;
  logic [BS-1:0]       count;
  logic                ready;

  logic [NDUT-1:0] clr_v;
  logic [NDUT-1:0] valid_v;
  logic [NDUT-1:0] ovr_v;
  logic [PW-1:0]   power_v [NDUT];
  logic [PW-1:0]   exp_v   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      goertzel_power_if #(.DW(DW), .BLOCK_SIZE_POW2(BS)) bus ();
      assign bus.s0_i     = s0;
      assign bus.s1_i     = s1;
      assign bus.valid_i  = valid_in;
      assign bus.count_i  = count;
      assign bus.ready_i  = ready;
      assign clr_v[gi]    = bus.clr_o;
      assign valid_v[gi]  = bus.valid_o;
      assign ovr_v[gi]    = bus.overrun_o;
      assign power_v[gi]  = bus.power_o;

      goertzel_power #(
        .COEFF           (COEFF_TAB[gi]),
        .COEFF_BITS      (CB),
        .DW              (DW),
        .BLOCK_SIZE_POW2 (BS)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  // Reference: exact integer arithmetic, floor on the Q-format product, then clamp.
  function automatic logic [PW-1:0] model_power(input int c, input int a, input int b);
    longint t;
    longint acc;
    logic [63:0] acc_bits;
    t   = (longint'(a) * longint'(c)) >>> FRAC;
    acc = longint'(a) * a + longint'(b) * b - t * b;
    if (acc < 0) return '0;
    if (acc > 64'sd4294967295) return '1;
    acc_bits = acc;
    return acc_bits[PW-1:0];
  endfunction

  task automatic start_block(input int a, input int b, input logic rdy, input string tag);
    ready    = rdy;
    s0       = W'(a);
    s1       = W'(b);
    valid_in = 1'b1;
    count    = '1;
    for (int i = 0; i < NDUT; i++) exp_v[i] = model_power(COEFF_TAB[i], a, b);
    @(posedge clk); #1;
    valid_in = 1'b0;
    count    = '0;
    n_checks++;
    if (clr_v !== '1 || valid_v !== '0) begin
      n_fail++;
      $display("FAIL %s clr_at_c1: clr=%b valid=%b required clr=1111 valid=0000", tag, clr_v, valid_v);
    end
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (clr_v !== '0 || valid_v !== '0) begin
        n_fail++;
        $display("FAIL %s busy_c%0d: clr=%b valid=%b required 0000/0000", tag, k, clr_v, valid_v);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (valid_v !== '1) begin
      n_fail++;
      $display("FAIL %s valid_at_c5: valid=%b required 1111", tag, valid_v);
    end
    for (int i = 0; i < NDUT; i++) begin
      n_checks++;
      if (power_v[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL %s power[coeff=%0d]: got %h required %h", tag, COEFF_TAB[i], power_v[i], exp_v[i]);
      end
    end
    $display("block %s s0=%0d s1=%0d power=%h %h %h %h", tag, a, b,
             power_v[0], power_v[1], power_v[2], power_v[3]);
  endtask

  task automatic finish_block(input string tag);
    @(posedge clk); #1;
    n_checks++;
    if (valid_v !== '0) begin
      n_fail++;
      $display("FAIL %s accept: valid=%b required 0000", tag, valid_v);
    end
  endtask

  task automatic test_reset();
    s0 = '0; s1 = '0; valid_in = 1'b0; count = '0; ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (clr_v !== '0 || valid_v !== '0 || ovr_v !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: clr=%b valid=%b ovr=%b required all 0", clr_v, valid_v, ovr_v);
    end
    for (int i = 0; i < NDUT; i++) begin
      n_checks++;
      if (power_v[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_power[%0d]: got %h required 0", i, power_v[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_directed();
    start_block(3, 4, 1'b1, "s3_4");
    n_checks++;
    if (power_v[0] !== 32'd25) begin
      n_fail++;
      $display("FAIL plan_coeff0: got %0d required 25", power_v[0]);
    end
    finish_block("s3_4");
    start_block(100, 100, 1'b1, "s100");
    n_checks++;
    if (power_v[1] !== 32'd10000) begin
      n_fail++;
      $display("FAIL plan_coeff1: got %0d required 10000", power_v[1]);
    end
    finish_block("s100");
    start_block(-32768, -32768, 1'b1, "sat");
    n_checks++;
    if (power_v[2] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL plan_saturate: got %h required ffffffff", power_v[2]);
    end
    finish_block("sat");
    start_block(32767, -32768, 1'b1, "edge_a");
    finish_block("edge_a");
    start_block(0, 0, 1'b1, "zero");
    finish_block("zero");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      start_block(a, b, 1'b1, $sformatf("rnd%0d", n));
      finish_block($sformatf("rnd%0d", n));
    end
  endtask

  task automatic test_hold();
    logic [NDUT-1:0] ovr_exp;
    int ovr_seen;
    ovr_seen = 0;
    start_block(1234, -567, 1'b0, "hold");
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      count    = '0;
      n_checks++;
      if (valid_v !== '1 || clr_v !== '0) begin
        n_fail++;
        $display("FAIL hold_c%0d: valid=%b clr=%b required 1111/0000", k, valid_v, clr_v);
      end
      for (int i = 0; i < NDUT; i++) begin
        n_checks++;
        if (power_v[i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL hold_power_c%0d[%0d]: got %h required %h", k, i, power_v[i], exp_v[i]);
        end
      end
      if (k == 4) begin
        s0 = 16'sd999; s1 = -16'sd999; valid_in = 1'b1; count = '1;
      end
      #1;
      ovr_exp = (k == 4) ? {NDUT{1'b1}} : {NDUT{1'b0}};
      n_checks++;
      if (ovr_v !== ovr_exp) begin
        n_fail++;
        $display("FAIL hold_overrun_c%0d: got %b required %b", k, ovr_v, ovr_exp);
      end
      if (ovr_v[0]) ovr_seen++;
    end
    n_checks++;
    if (ovr_seen != 1) begin
      n_fail++;
      $display("FAIL hold_overrun_count: got %0d required 1", ovr_seen);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (valid_v !== '0 || clr_v !== '0) begin
      n_fail++;
      $display("FAIL hold_accept: valid=%b clr=%b required 0000/0000", valid_v, clr_v);
    end
    $display("hold released after 10 cycles, overrun pulses=%0d", ovr_seen);
    start_block(7, -9, 1'b1, "after_hold");
    finish_block("after_hold");
  endtask

  task automatic test_accept_collision();
    start_block(-2000, 1500, 1'b1, "coll");
    s0 = 16'sd55; s1 = 16'sd66; valid_in = 1'b1; count = '1;
    #1;
    n_checks++;
    if (ovr_v !== '1) begin
      n_fail++;
      $display("FAIL coll_overrun: got %b required 1111", ovr_v);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    count    = '0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (valid_v !== '0 || clr_v !== '0) begin
        n_fail++;
        $display("FAIL coll_no_capture_%0d: valid=%b clr=%b required 0000/0000", k, valid_v, clr_v);
      end
      @(posedge clk); #1;
    end
    $display("collision block end discarded");
  endtask

  task automatic test_nonfinal();
    for (int c = 0; c < 7; c++) begin
      s0       = W'(int'($urandom_range(0, 65535)));
      s1       = W'(int'($urandom_range(0, 65535)));
      valid_in = 1'b1;
      count    = BS'(c);
      #1;
      n_checks++;
      if (ovr_v !== '0) begin
        n_fail++;
        $display("FAIL nonfinal_ovr_%0d: got %b required 0000", c, ovr_v);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      n_checks++;
      if (clr_v !== '0 || valid_v !== '0) begin
        n_fail++;
        $display("FAIL nonfinal_%0d: clr=%b valid=%b required 0000/0000", c, clr_v, valid_v);
      end
      @(posedge clk); #1;
    end
    $display("non-final samples 0..6 ignored");
    start_block(-4321, 8765, 1'b1, "final7");
    finish_block("final7");
  endtask

  task automatic test_reset_mid();
    start_block(1000, -700, 1'b1, "pre_rst");
    finish_block("pre_rst");
    s0 = 16'sd500; s1 = 16'sd300; valid_in = 1'b1; count = '1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    count    = '0;
    n_checks++;
    if (clr_v !== '1) begin
      n_fail++;
      $display("FAIL rstmid_clr: got %b required 1111", clr_v);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (clr_v !== '0 || valid_v !== '0 || ovr_v !== '0) begin
      n_fail++;
      $display("FAIL rstmid_flags: clr=%b valid=%b ovr=%b required all 0", clr_v, valid_v, ovr_v);
    end
    for (int i = 0; i < NDUT; i++) begin
      n_checks++;
      if (power_v[i] !== '0) begin
        n_fail++;
        $display("FAIL rstmid_power[%0d]: got %h required 0", i, power_v[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (clr_v !== '0 || valid_v !== '0) begin
        n_fail++;
        $display("FAIL rstmid_quiet_%0d: clr=%b valid=%b required 0000/0000", k, clr_v, valid_v);
      end
    end
    $display("mid-computation reset aborted block");
    start_block(-321, 4567, 1'b1, "post_rst");
    finish_block("post_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_accept_collision();
    test_nonfinal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
